// File: rtl/mcs4_pkg.sv
// Shared definitions for the MCS-4 bus controller: phase encoding,
// default ROM address width and the nibble slots the core fills in A1..A3.
package mcs4_pkg;

   typedef enum logic [2:0] {
      PH_A1 = 3'd0,
      PH_A2 = 3'd1,
      PH_A3 = 3'd2,
      PH_M1 = 3'd3,
      PH_M2 = 3'd4,
      PH_X1 = 3'd5,
      PH_X2 = 3'd6,
      PH_X3 = 3'd7
   } phase_e;

   localparam int MCS4_ROM_AW = 12;

   // Bit offset of the nibble captured in each address phase
   localparam int NIB_SLOT_A1 = 0;
   localparam int NIB_SLOT_A2 = 4;
   localparam int NIB_SLOT_A3 = 8;

endpackage

// File: rtl/mcs4_phase_div.sv
// Phase clock-enable divider. Produces one ce pulse every PHASE_DIV clocks;
// while the gate is active at the terminal count the counter parks there,
// so ce fires in the same clock the gate releases.
module mcs4_phase_div #(
   parameter int PHASE_DIV = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic gate_i,
   output logic ce_o,
   output logic tc_o
);

   localparam int CW = $clog2(PHASE_DIV);
   localparam logic [CW-1:0] TC = CW'(PHASE_DIV - 1);

   logic [CW-1:0] div_cnt_q;
   logic [CW-1:0] div_cnt_d;

   assign tc_o = (div_cnt_q == TC);
   assign ce_o = tc_o && !gate_i;

   // Next count: wrap at terminal count unless gated, then hold
   always_comb begin
      div_cnt_d = div_cnt_q + CW'(1);
      if (tc_o) begin
         div_cnt_d = gate_i ? TC : '0;
      end
   end

   // Counter register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_cnt_q <= '0;
      end else begin
         div_cnt_q <= div_cnt_d;
      end
   end

endmodule

// File: rtl/mcs4_bus_ctrl.sv
// MCS-4 bus controller: sequences the i4004 8-phase instruction cycle,
// holds the core in reset after power-up, fetches instruction bytes from a
// req/ack ROM port and returns them in M1/M2, with run/halt/step control.
// Optional instruction trace outputs are built when MCS4_TRACE_EN is defined.
module mcs4_bus_ctrl
   import mcs4_pkg::*;
#(
   parameter int PHASE_DIV  = 4,
   parameter int RST_PHASES = 64,
   parameter int ROM_AW     = MCS4_ROM_AW
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              run,
   input  logic              step,
   output logic              cpu_ce,
   output logic              cpu_rst,
   input  logic [3:0]        cpu_dbus_out,
   output logic [3:0]        cpu_dbus_in,
   output logic              sync,
   output logic [2:0]        phase,
   output logic              halted,
   output logic              rom_req,
   output logic [ROM_AW-1:0] rom_addr,
   input  logic              rom_ack,
   input  logic [7:0]        rom_data
`ifdef MCS4_TRACE_EN
   ,
   output logic              trace_valid,
   output logic [ROM_AW-1:0] trace_addr,
   output logic [7:0]        trace_instr,
   output logic [15:0]       trace_cycles
`endif
);

   localparam int RCW = $clog2(RST_PHASES + 1);
   localparam logic [RCW-1:0] RST_LAST = RCW'(RST_PHASES - 1);

   phase_e                 phase_q;
   logic                   cpu_rst_q;
   logic [RCW-1:0]         rst_cnt_q;
   logic [7:0]             addr_q;
   logic [MCS4_ROM_AW-1:0] fetch_addr;
   logic [ROM_AW-1:0]      rom_addr_q;
   logic                   rom_req_q;
   logic [7:0]             instr_q;
   logic                   data_valid_q;
   logic                   step_pend_q;

   logic ce;
   logic tc;
   logic core_ce;
   logic ack_take;
   logic gate_m1;
   logic gate_x3;
   logic gate;

   // An ack only counts while a fetch is outstanding; it also lets M1 end in
   // the same clock, so the byte is never a clock late.
   assign ack_take = rom_ack && rom_req_q;
   assign gate_m1  = (phase_q == PH_M1) && !data_valid_q && !ack_take;
   assign gate_x3  = (phase_q == PH_X3) && !run && !step_pend_q;
   assign gate     = !cpu_rst_q && (gate_m1 || gate_x3);
   assign core_ce  = ce && !cpu_rst_q;

   mcs4_phase_div #(
      .PHASE_DIV(PHASE_DIV)
   ) u_div (
      .clk    (clk),
      .rst_n  (rst_n),
      .gate_i (gate),
      .ce_o   (ce),
      .tc_o   (tc)
   );

   // Phase sequencer: counts reset-hold phases with phase frozen at A1,
   // then advances the phase on every enable
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         phase_q   <= PH_A1;
         cpu_rst_q <= 1'b1;
         rst_cnt_q <= '0;
      end else if (ce) begin
         if (cpu_rst_q) begin
            rst_cnt_q <= rst_cnt_q + RCW'(1);
            if (rst_cnt_q == RST_LAST) begin
               cpu_rst_q <= 1'b0;
            end
         end else begin
            phase_q <= phase_e'(phase_q + 3'd1);
         end
      end
   end

   // The full fetch address is the two stored nibbles plus whatever the
   // core is driving in A3, so rom_addr can load on the A3 enable itself
   always_comb begin
      fetch_addr                      = {4'h0, addr_q};
      fetch_addr[NIB_SLOT_A3 +: 4]    = cpu_dbus_out;
   end

   // Address capture, ROM handshake and fetched-byte latch
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_q       <= '0;
         rom_addr_q   <= '0;
         rom_req_q    <= 1'b0;
         instr_q      <= '0;
         data_valid_q <= 1'b0;
      end else begin
         if (core_ce) begin
            case (phase_q)
               PH_A1: addr_q[NIB_SLOT_A1 +: 4] <= cpu_dbus_out;
               PH_A2: addr_q[NIB_SLOT_A2 +: 4] <= cpu_dbus_out;
               PH_A3: begin
                  rom_addr_q <= ROM_AW'(fetch_addr);
                  rom_req_q  <= 1'b1;
               end
               PH_M2: data_valid_q <= 1'b0;
               default: ;
            endcase
         end
         if (ack_take) begin
            instr_q      <= rom_data;
            data_valid_q <= 1'b1;
            rom_req_q    <= 1'b0;
         end
      end
   end

   // Single-step request: armed by a step while not running, consumed when
   // the granted cycle leaves X3
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         step_pend_q <= 1'b0;
      end else if (step && !run) begin
         step_pend_q <= 1'b1;
      end else if (core_ce && (phase_q == PH_X3)) begin
         step_pend_q <= 1'b0;
      end
   end

   // Byte return to the core: high nibble in M1, low nibble in M2
   always_comb begin
      cpu_dbus_in = 4'h0;
      case (phase_q)
         PH_M1:   cpu_dbus_in = instr_q[7:4];
         PH_M2:   cpu_dbus_in = instr_q[3:0];
         default: cpu_dbus_in = 4'h0;
      endcase
   end

   assign cpu_ce   = ce;
   assign cpu_rst  = cpu_rst_q;
   assign phase    = phase_q;
   assign sync     = (phase_q == PH_X3);
   assign halted   = tc && gate_x3 && !cpu_rst_q;
   assign rom_req  = rom_req_q;
   assign rom_addr = rom_addr_q;

`ifdef MCS4_TRACE_EN
   logic              trace_valid_q;
   logic [ROM_AW-1:0] trace_addr_q;
   logic [7:0]        trace_instr_q;
   logic [15:0]       trace_cycles_q;

   // Instruction trace: one record per completed fetch, plus a wrapping
   // count of finished instruction cycles
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         trace_valid_q  <= 1'b0;
         trace_addr_q   <= '0;
         trace_instr_q  <= '0;
         trace_cycles_q <= '0;
      end else begin
         trace_valid_q <= core_ce && (phase_q == PH_M2);
         if (core_ce && (phase_q == PH_M2)) begin
            trace_addr_q  <= rom_addr_q;
            trace_instr_q <= instr_q;
         end
         if (core_ce && (phase_q == PH_X3)) begin
            trace_cycles_q <= trace_cycles_q + 16'd1;
         end
      end
   end

   assign trace_valid  = trace_valid_q;
   assign trace_addr   = trace_addr_q;
   assign trace_instr  = trace_instr_q;
   assign trace_cycles = trace_cycles_q;
`endif

endmodule
